// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-granular stream mux and its arbiter.
package stream_arb_pkg;

    localparam int MAX_STREAMS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [31:0] onehot_to_bin(input logic [MAX_STREAMS-1:0] oh);
        logic [31:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_STREAMS; i++) begin
            if (oh[i]) bin = bin | 32'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register; accepts a new beat whenever the
// slot is empty or being drained on the same edge.
module stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_packet_mux.sv
// Packet-granular N:1 stream mux: an external round-robin arbiter picks the
// owner, which keeps the output until its last beat is accepted.
module stream_packet_mux
    import stream_arb_pkg::*;
#(
    parameter int STREAM_COUNT = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = $clog2(STREAM_COUNT)
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [STREAM_COUNT-1:0]            s_valid,
    input  logic [STREAM_COUNT*DATA_WIDTH-1:0] s_data,
    input  logic [STREAM_COUNT-1:0]            s_last,
    output logic [STREAM_COUNT-1:0]            s_ready,
    output logic                               m_valid,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic                               m_last,
    output logic [ID_WIDTH-1:0]                m_id,
    input  logic                               m_ready,
    output logic [STREAM_COUNT-1:0]            arb_req,
    input  logic [STREAM_COUNT-1:0]            arb_grant,
    output logic                               arb_en
);

    localparam int PW = DATA_WIDTH + 1 + ID_WIDTH;

    arb_state_t              state, state_nxt;
    logic [STREAM_COUNT-1:0] sel, sel_nxt;
    logic                    grant_ok;
    logic                    slot_ready;
    logic                    beat_vld;
    logic [DATA_WIDTH-1:0]   mux_data;
    logic                    mux_last;
    logic [ID_WIDTH-1:0]     sel_id;
    logic [PW-1:0]           out_payload;

    assign arb_req = s_valid;

    // Only a clean one-hot grant to a stream that is actually valid starts a packet.
    assign grant_ok = (arb_grant != '0)
                   && ((arb_grant & (arb_grant - STREAM_COUNT'(1))) == '0)
                   && ((arb_grant & s_valid) != '0);

    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if (sel[i]) begin
                mux_data = mux_data | s_data[i*DATA_WIDTH +: DATA_WIDTH];
                mux_last = mux_last | s_last[i];
            end
        end
    end

    assign sel_id   = ID_WIDTH'(onehot_to_bin(MAX_STREAMS'(sel)));
    assign s_ready  = (state == XFER) ? (sel & {STREAM_COUNT{slot_ready}}) : '0;
    assign beat_vld = |(s_valid & s_ready);
    assign arb_en   = (state == XFER) && beat_vld && mux_last;

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    state_nxt = XFER;
                    sel_nxt   = arb_grant;
                end
            end
            XFER: begin
                if (arb_en) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    stream_out_reg #(
        .WIDTH (PW)
    ) u_out_reg (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (beat_vld),
        .in_ready  (slot_ready),
        .in_data   ({mux_last, sel_id, mux_data}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (out_payload)
    );

    assign m_data = out_payload[DATA_WIDTH-1:0];
    assign m_id   = out_payload[DATA_WIDTH +: ID_WIDTH];
    assign m_last = out_payload[PW-1];

endmodule

// File: tb/tb_stream_packet_mux.sv
// Directed bench for stream_packet_mux: per-stream source queues, an expected
// beat scoreboard, and a small round-robin arbiter model.
module tb_stream_packet_mux;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        id;
    } exp_t;

    logic        clk;
    logic        nrst;
    logic [1:0]  s_valid;
    logic [63:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_id;
    logic        m_ready;
    logic [1:0]  arb_req;
    logic [1:0]  arb_grant;
    logic        arb_en;

    logic [1:0]  rr_grant;
    logic [1:0]  force_grant;
    logic        use_rr;
    int          ptr;
    logic [1:0]  gate;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  expq[$];

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int out_cnt, en_cnt, first_out, last_out;
    logic        stalled;
    logic [31:0] stall_d;
    logic        stall_l, stall_i;

    stream_packet_mux #(
        .STREAM_COUNT (2),
        .DATA_WIDTH   (32)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_id      (m_id),
        .m_ready   (m_ready),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .arb_en    (arb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rr_grant = 2'b00;
        if (ptr == 0) rr_grant = s_valid[0] ? 2'b01 : (s_valid[1] ? 2'b10 : 2'b00);
        else          rr_grant = s_valid[1] ? 2'b10 : (s_valid[0] ? 2'b01 : 2'b00);
        arb_grant = use_rr ? rr_grant : force_grant;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qhead(input int s);
        beat_t b;
        b = '0;
        if (s == 0 && q0.size() > 0) b = q0[0];
        if (s == 1 && q1.size() > 0) b = q1[0];
        return b;
    endfunction

    task automatic push_pkt(input int s, input logic [31:0] base, input int n);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            b.data = base + 32'(k);
            b.last = (k == n - 1);
            if (s == 0) q0.push_back(b);
            else        q1.push_back(b);
            e.data = b.data;
            e.last = b.last;
            e.id   = (s != 0);
            expq.push_back(e);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < 2; i++) begin
            if (gate[i] && qsize(i) > 0) begin
                b = qhead(i);
                s_valid[i]         = 1'b1;
                s_data[i*32 +: 32] = b.data;
                s_last[i]          = b.last;
            end else begin
                s_valid[i]         = 1'b0;
                s_data[i*32 +: 32] = '0;
                s_last[i]          = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, score output beats, then advance sources.
    task automatic cyc();
        logic [1:0]  acc, gr;
        logic        ohs, ae, exp_ae;
        logic [31:0] od;
        logic        ol, oi;
        beat_t       b;
        exp_t        e;
        #1;
        acc = s_valid & s_ready;
        ohs = m_valid & m_ready;
        od  = m_data;
        ol  = m_last;
        oi  = m_id;
        ae  = arb_en;
        gr  = arb_grant;
        exp_ae = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b = qhead(i);
            if (acc[i] && b.last) exp_ae = 1'b1;
        end
        chk("arb_req", arb_req, s_valid);
        chk("arb_en", ae, exp_ae);
        chk("s_ready_onehot", ($countones(s_ready) <= 1), 1'b1);
        if (stalled) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", od, stall_d);
            chk("stall_last", ol, stall_l);
            chk("stall_id", oi, stall_i);
        end
        stalled = m_valid & ~m_ready;
        stall_d = od;
        stall_l = ol;
        stall_i = oi;
        if (ae) en_cnt++;
        if (ohs) begin
            chk("beat_expected", (expq.size() > 0), 1'b1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("m_data", od, e.data);
                chk("m_last", ol, e.last);
                chk("m_id", oi, e.id);
            end
            out_cnt++;
            if (first_out < 0) first_out = cyc_no;
            last_out = cyc_no;
        end
        @(posedge clk);
        #1;
        cyc_no++;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        if (use_rr && ae && gr != 2'b00) ptr = gr[0] ? 1 : 0;
        drive();
    endtask

    task automatic run_pkts(input int budget);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            cyc();
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && (expq.size() == 0) && !m_valid;
        end
        chk("drain_in_budget", done, 1'b1);
    endtask

    task automatic new_scenario();
        out_cnt   = 0;
        en_cnt    = 0;
        first_out = -1;
        last_out  = -1;
    endtask

    initial begin
        bit mr_pat [12] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        int n;

        nrst = 1'b0;
        m_ready = 1'b1;
        gate = 2'b11;
        use_rr = 1'b0;
        force_grant = 2'b01;
        ptr = 0;
        stalled = 1'b0;
        stall_d = '0;
        stall_l = 1'b0;
        stall_i = 1'b0;
        s_valid = '0;
        s_data = '0;
        s_last = '0;
        new_scenario();

        // Held in reset with a valid, granted stream: nothing may move.
        push_pkt(0, 32'hA0, 3);
        drive();
        @(posedge clk);
        #2;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_id", m_id, 1'b0);
        chk("rst_s_ready", s_ready, 2'b00);
        chk("rst_arb_en", arb_en, 1'b0);
        @(negedge clk);
        nrst = 1'b1;

        // Three-beat packet from stream 0, sink always ready.
        run_pkts(20);
        chk("p3_out_cnt", out_cnt, 3);
        chk("p3_consecutive", last_out - first_out, 2);
        chk("p3_en_cnt", en_cnt, 1);

        // Two streams contending under round-robin: whole packets alternate.
        new_scenario();
        use_rr = 1'b1;
        push_pkt(0, 32'h10, 2);
        push_pkt(1, 32'h20, 2);
        push_pkt(0, 32'h30, 2);
        push_pkt(1, 32'h40, 2);
        drive();
        run_pkts(60);
        chk("rr_out_cnt", out_cnt, 8);
        chk("rr_en_cnt", en_cnt, 4);

        // Sink backpressure during a 4-beat packet.
        new_scenario();
        use_rr = 1'b0;
        force_grant = 2'b01;
        push_pkt(0, 32'h50, 4);
        drive();
        for (int k = 0; k < 12; k++) begin
            m_ready = mr_pat[k];
            cyc();
        end
        m_ready = 1'b1;
        run_pkts(20);
        chk("bp_out_cnt", out_cnt, 4);

        // Owner drops valid mid-packet while the grant moves to the other stream.
        new_scenario();
        force_grant = 2'b10;
        push_pkt(1, 32'h60, 4);
        push_pkt(0, 32'h70, 2);
        drive();
        n = 0;
        while (q1.size() > 3 && n < 10) begin
            cyc();
            n++;
        end
        chk("own_first_beat", q1.size(), 3);
        gate[1] = 1'b0;
        force_grant = 2'b01;
        drive();
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk("own_s_ready0", s_ready[0], 1'b0);
        end
        gate[1] = 1'b1;
        drive();
        run_pkts(40);
        chk("own_out_cnt", out_cnt, 6);

        // Multi-hot and zero grants in IDLE are ignored.
        new_scenario();
        force_grant = 2'b11;
        push_pkt(0, 32'h80, 1);
        push_pkt(1, 32'h90, 1);
        drive();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) force_grant = 2'b00;
            cyc();
            #1;
            chk("badgrant_s_ready", s_ready, 2'b00);
            chk("badgrant_arb_en", arb_en, 1'b0);
            chk("badgrant_m_valid", m_valid, 1'b0);
        end
        use_rr = 1'b1;
        run_pkts(30);
        chk("single_en_cnt", en_cnt, 2);

        // Reset in the middle of a packet.
        new_scenario();
        use_rr = 1'b0;
        force_grant = 2'b01;
        push_pkt(0, 32'hB0, 4);
        drive();
        n = 0;
        while (out_cnt < 2 && n < 20) begin
            cyc();
            n++;
        end
        chk("mid_rst_two_beats", out_cnt, 2);
        nrst = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 1'b0);
        chk("mid_rst_m_data", m_data, 32'h0);
        chk("mid_rst_m_last", m_last, 1'b0);
        chk("mid_rst_m_id", m_id, 1'b0);
        chk("mid_rst_s_ready", s_ready, 2'b00);
        chk("mid_rst_arb_en", arb_en, 1'b0);
        q0.delete();
        q1.delete();
        expq.delete();
        stalled = 1'b0;
        drive();
        @(negedge clk);
        nrst = 1'b1;
        new_scenario();
        push_pkt(0, 32'hC0, 3);
        drive();
        run_pkts(30);
        chk("post_rst_out_cnt", out_cnt, 3);
        chk("post_rst_en_cnt", en_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
